// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- sequential ALU with a single-request handshake.
//
// Accepts one request when idle. Single-step ops finish on the next edge.
// Unsigned multiply (op 100) runs shift-add over m edges. Results and status
// flags are registered and held until the next completion.
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_valid             : request strobe, sampled only while o_ready=1
//   i_op[2:0]           : operation code
//   i_argA, i_argB[m]   : operands, latched on acceptance
//   o_ready             : idle and able to accept
//   o_valid             : one-cycle completion pulse
//   o_result[m]         : registered result
//   o_status[3:0]       : {all ones, even parity, result MSB, error/overflow}
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int m = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [2:0]   i_op,
    input  logic [m-1:0] i_argA,
    input  logic [m-1:0] i_argB,
    output logic         o_ready,
    output logic         o_valid,
    output logic [m-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int CW = $clog2(m);
    localparam logic [CW-1:0] LAST = CW'(m - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [m-1:0]       a_q, a_d;
    logic [m-1:0]       b_q, b_d;           // also the multiplier shift register
    logic [2*m-1:0]     acc_q, acc_d;       // 2m-bit partial-product sum
    logic [2*m-1:0]     mcand_q, mcand_d;   // multiplicand shifted left per step
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [m-1:0]       result_q, result_d;
    logic [3:0]         status_q, status_d;
    logic               valid_q, valid_d;

    logic [m-1:0]       alu_res;
    logic               alu_err;
    logic [2*m-1:0]     acc_nxt;

    // Status flags always derive from the value actually written to o_result.
    function automatic logic [3:0] mk_status(input logic [m-1:0] r, input logic err);
        return {&r, ~^r, r[m-1], err};
    endfunction

    // Single-step datapath, operating on the latched request only.
    always_comb begin
        logic [m-1:0] diff;
        logic [m-1:0] mask;
        logic [m-1:0] mag;
        alu_res = '0;
        alu_err = 1'b0;
        diff    = a_q - b_q;
        // A shift amount >= m yields an all-zero mask, which both leaves A
        // unchanged and flags the out-of-range bit index.
        mask    = {{(m-1){1'b0}}, 1'b1} << b_q;
        mag     = {1'b0, a_q[m-2:0]};
        case (op_q)
            3'b000: begin
                alu_res = diff;
                alu_err = (a_q[m-1] != b_q[m-1]) && (diff[m-1] != a_q[m-1]);
            end
            3'b001: alu_res = {{(m-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            3'b010: begin
                alu_res = a_q & ~mask;
                alu_err = (mask == '0);
            end
            // Negative zero falls out naturally: -(0) is 0.
            3'b011: alu_res = a_q[m-1] ? (~mag + 1'b1) : a_q;
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    assign acc_nxt = acc_q + (b_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        status_d = status_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    op_d = i_op;
                    a_d  = i_argA;
                    b_d  = i_argB;
                    if (i_op == 3'b100) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        mcand_d = {{m{1'b0}}, i_argA};
                        cnt_d   = '0;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d  = S_IDLE;
                valid_d  = 1'b1;
                result_d = alu_res;
                status_d = mk_status(alu_res, alu_err);
            end
            S_MUL: begin
                acc_d   = acc_nxt;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    result_d = acc_nxt[m-1:0];
                    status_d = mk_status(acc_nxt[m-1:0], |acc_nxt[2*m-1:m]);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_status = status_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic [2:0] i_op;
    logic [7:0] i_argA;
    logic [7:0] i_argB;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_result;
    logic [3:0] o_status;

    int checks = 0;
    int failures = 0;

    seq_alu #(.m(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op(i_op),
        .i_argA(i_argA), .i_argB(i_argB), .o_ready(o_ready), .o_valid(o_valid),
        .o_result(o_result), .o_status(o_status)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [11:0] model(input int op, input int a, input int b);
        int r, sa, sb, s, p, ones;
        bit err;
        err = 0;
        r = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin s = sa - sb; r = (a - b + 256) % 256; err = (s > 127) || (s < -128); end
            1: r = (sa < sb) ? 1 : 0;
            2: if (b < 8) r = a & (255 - (1 << b)); else begin r = a; err = 1; end
            3: r = (a >= 128) ? (256 - (a - 128)) % 256 : a;
            4: begin p = a * b; r = p % 256; err = (p > 255); end
            default: begin r = 0; err = 1; end
        endcase
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
        return {(r == 255), (ones % 2 == 0), (r >= 128), err, r[7:0]};
    endfunction

    task automatic run_op(input int op, input int a, input int b);
        logic [11:0] e;
        int lat, explat;
        bit done;
        e = model(op, a, b);
        explat = (op == 4) ? 8 : 1;
        chk("ready_idle", o_ready, 1);
        i_valid = 1; i_op = op[2:0]; i_argA = a[7:0]; i_argB = b[7:0];
        @(posedge i_clk); #1;
        i_valid = 0;
        lat = 0; done = 0;
        while (!done && lat < 20) begin
            chk("busy_ready", o_ready, 0);
            // Scramble inputs and strobe i_valid while busy: must be ignored.
            i_valid = 1'($urandom_range(0, 1));
            i_op = 3'($urandom); i_argA = 8'($urandom); i_argB = 8'($urandom);
            @(posedge i_clk); #1;
            lat++;
            if (o_valid) done = 1;
        end
        i_valid = 0;
        chk("latency", lat, explat);
        chk("result", o_result, e[7:0]);
        chk("status", o_status, e[11:8]);
        @(posedge i_clk); #1;
        chk("vld_pulse", o_valid, 0);
        chk("ready_after", o_ready, 1);
        chk("result_hold", o_result, e[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1; i_valid = 0; i_op = 0; i_argA = 0; i_argB = 0;
        #3;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_status", o_status, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;

        run_op(0, 8'h05, 8'h07);
        chk("dir_sub1", {o_status, o_result}, 12'h2FE);
        run_op(0, 8'h80, 8'h01);
        chk("dir_sub2", {o_status, o_result}, 12'h17F);
        run_op(1, 8'hFF, 8'h01);
        chk("dir_cmp1", {o_status, o_result}, 12'h001);
        run_op(1, 8'h01, 8'hFF);
        chk("dir_cmp2", {o_status, o_result}, 12'h400);
        run_op(2, 8'hFF, 3);
        chk("dir_clr1", {o_status, o_result}, 12'h2F7);
        run_op(2, 8'hFF, 8);
        chk("dir_clr2", {o_status, o_result}, 12'hFFF);
        run_op(3, 8'h85, 0);
        chk("dir_sm1", {o_status, o_result}, 12'h2FB);
        run_op(3, 8'h80, 0);
        chk("dir_sm2", {o_status, o_result}, 12'h400);
        run_op(7, 8'h12, 8'h34);
        chk("dir_rsv", {o_status, o_result}, 12'h500);
        run_op(4, 8'h10, 8'h11);
        chk("dir_mul", {o_status, o_result}, 12'h110);
        run_op(2, 8'hA5, 7);
        run_op(4, 8'hFF, 8'hFF);

        // Reset in the middle of a multiply.
        run_op(0, 8'h05, 8'h07);
        i_valid = 1; i_op = 3'b100; i_argA = 8'h10; i_argB = 8'h11;
        @(posedge i_clk); #1;
        i_valid = 0;
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1;
        #1;
        chk("abort_result", o_result, 0);
        chk("abort_status", o_status, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_ready", o_ready, 1);
        @(posedge i_clk); #1;
        chk("abort_hold", {o_ready, o_valid, o_status, o_result}, 14'h2000);
        i_rst = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_clk); #1;
            chk("abort_no_vld", o_valid, 0);
        end
        run_op(0, 8'h03, 8'h01);
        chk("post_rst_sub", {o_status, o_result}, 12'h002);

        // Random traffic, biased toward boundary operands.
        for (int n = 0; n < 300; n++) begin
            int op, a, b;
            op = $urandom_range(0, 7);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            case ($urandom_range(0, 5))
                0: a = 8'h80;
                1: b = 8'h7F;
                2: b = $urandom_range(0, 9);
                3: a = 8'hFF;
                default: ;
            endcase
            run_op(op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter m, default 8: operand/result width in bits; legal m >= 2.
REQ-002 Port i_clk  input  1: single clock, all state on rising edge.
REQ-003 Port i_rst  input  1: asynchronous, active-high reset.
REQ-004 Port i_valid  input  1: request strobe; sampled only while o_ready=1.
REQ-005 Port i_op  input  3: operation code, latched on acceptance.
REQ-006 Port i_argA  input  m: operand A, latched on acceptance.
REQ-007 Port i_argB  input  m: operand B, latched on acceptance.
REQ-008 Port o_ready  output  1: high when idle and able to accept a request.
REQ-009 Port o_valid  output  1: one-cycle pulse when o_result/o_status are updated.
REQ-010 Port o_result  output  m: registered result, held until the next completion.
REQ-011 Port o_status  output  4: registered flags; [0] error/overflow, [1] result MSB, [2] even parity of result (zero ones counts as even), [3] result all ones.

Function
REQ-012 Acceptance occurs on the rising edge where i_valid=1 and o_ready=1 (edge E0); i_valid at any other time is ignored, not queued.
REQ-013 FSM states: IDLE (o_ready=1), EXEC (single-step ops), MUL (iterative multiply); IDLE->EXEC or IDLE->MUL on acceptance, EXEC->IDLE after one edge, MUL->IDLE after m edges.
REQ-014 Latency: op 100 completes at edge E0+m; all other codes complete at edge E0+1; at the completion edge o_result, o_status and o_valid=1 are written together, and the FSM returns to IDLE.
REQ-015 o_ready is 0 from E0 until the completion edge; earliest next acceptance is the edge after completion (max throughput one single-step op per 2 cycles).
REQ-016 o_valid is 1 for exactly one cycle per completed operation.
REQ-017 Op 000 subtract: result = (A - B) mod 2^m; status[0] = signed U2 overflow.
REQ-018 Op 001 signed compare: result = 1 if A < B in U2, else 0 (zero-extended to m bits); status[0] = 0.
REQ-019 Op 010 clear bit: B taken unsigned; if B < m, result = A with bit B cleared, status[0]=0; if B >= m, result = A unchanged, status[0]=1.
REQ-020 Op 011 sign-magnitude to U2: A[m-1]=0 -> result = A; A[m-1]=1 -> result = -(A with MSB cleared) in U2; negative zero (MSB only) -> result 0; status[0]=0.
REQ-021 Op 100 unsigned multiply: shift-add, one partial-product bit per edge over m edges; result = low m bits of A*B; status[0] = 1 if upper m bits of the 2m-bit product are nonzero.
REQ-022 Ops 101-111 reserved: single-step, result = 0, status[0]=1, other flags computed from result.
REQ-023 status[3:1] are always computed from the final result value written to o_result.
REQ-024 Operand/op changes on inputs after E0 do not affect an operation in progress.

Reset
REQ-025 While i_rst=1, regardless of clock: state=IDLE, o_result=0, o_status=0, o_valid=0, o_ready=1.
REQ-026 Reset asserted mid-operation (EXEC or MUL) aborts it; no o_valid is produced for the aborted request, and o_result/o_status read 0.
REQ-027 After i_rst deasserts, the first rising edge with i_valid=1 is a legal acceptance.

Verification (m=8)
REQ-028 Sub A=0x05 B=0x07 -> o_result=0xFE, o_status=4'b0010, o_valid one cycle at E0+1; then sub A=0x80 B=0x01 -> 0x7F, 4'b0001.
REQ-029 Compare A=0xFF B=0x01 -> 0x01, 4'b0000; compare A=0x01 B=0xFF -> 0x00, 4'b0100.
REQ-030 Clear bit A=0xFF B=3 -> 0xF7, 4'b0010; A=0xFF B=8 -> 0xFF, 4'b1111.
REQ-031 SM->U2 A=0x85 -> 0xFB, 4'b0010; A=0x80 -> 0x00, 4'b0100; reserved op 111 -> 0x00, 4'b0101.
REQ-032 Multiply A=0x10 B=0x11 -> 0x10, 4'b0001, o_valid exactly at E0+8, o_ready=0 for edges E0..E0+8, i_valid pulses during busy produce no extra o_valid.
REQ-033 Assert i_rst at E0+4 of a multiply -> outputs 0 immediately, no o_valid, o_ready=1; subsequent sub A=0x03 B=0x01 -> 0x02, 4'b0000.
